// File: rtl/alu_issue_pkg.sv
// Shared constants and payload layout for the ALU operand issue stage.
package alu_issue_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;

    // ALU opcodes understood by the execute unit
    localparam logic [OPC_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPC_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [OPC_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [OPC_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [OPC_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OPC_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OPC_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [OPC_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [OPC_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [OPC_W-1:0] ALU_SRA  = 4'b1101;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 / funct7 values needed by the decoder
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    // Issue payload, MSB first
    typedef struct packed {
        logic [XLEN-1:0]  op_1;
        logic [XLEN-1:0]  op_2;
        logic [OPC_W-1:0] alu_opcode;
        logic [REG_W-1:0] rd_addr;
        logic             rd_wr_en;
        logic             illegal;
    } issue_payload_t;

    // Field offsets inside the flattened payload vector
    localparam int unsigned PL_ILLEGAL_LSB = 0;
    localparam int unsigned PL_WR_EN_LSB   = 1;
    localparam int unsigned PL_RD_LSB      = 2;
    localparam int unsigned PL_OPC_LSB     = PL_RD_LSB + REG_W;
    localparam int unsigned PL_OP2_LSB     = PL_OPC_LSB + OPC_W;
    localparam int unsigned PL_OP1_LSB     = PL_OP2_LSB + XLEN;
    localparam int unsigned PAYLOAD_W      = PL_OP1_LSB + XLEN;

endpackage

// File: rtl/alu_operand_issue_if.sv
// Upstream instruction handshake and downstream issue handshake of the issue stage.
interface alu_operand_issue_if;
    import alu_issue_pkg::*;

    logic                instr_valid_in;
    logic                instr_ready_out;
    logic [INSTR_W-1:0]  instr_in;
    logic [XLEN-1:0]     pc_in;
    logic [XLEN-1:0]     rs1_data_in;
    logic [XLEN-1:0]     rs2_data_in;
    logic                flush_in;
    logic                issue_valid_out;
    logic                issue_ready_in;
    logic [XLEN-1:0]     op_1_out;
    logic [XLEN-1:0]     op_2_out;
    logic [OPC_W-1:0]    alu_opcode_out;
    logic [REG_W-1:0]    rd_addr_out;
    logic                rd_wr_en_out;
    logic                illegal_out;

    // Stage view
    modport slave (
        input  instr_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, flush_in, issue_ready_in,
        output instr_ready_out, issue_valid_out, op_1_out, op_2_out, alu_opcode_out,
        output rd_addr_out, rd_wr_en_out, illegal_out
    );

    // Surrounding pipeline view
    modport master (
        output instr_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, flush_in, issue_ready_in,
        input  instr_ready_out, issue_valid_out, op_1_out, op_2_out, alu_opcode_out,
        input  rd_addr_out, rd_wr_en_out, illegal_out
    );

endinterface

// File: rtl/alu_issue_skid.sv
// Generic 2-entry valid/ready skid buffer: entry A drives the output, entry B
// absorbs the one item that can arrive while A is stalled.
module alu_issue_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             a_valid_q, a_valid_d;
    logic [WIDTH-1:0] a_data_q,  a_data_d;
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] b_data_q,  b_data_d;
    logic             ready_q,   ready_d;
    logic             accept;
    logic             a_free;

    // Entry movement: B drains into A first to keep order, otherwise input lands in A or B
    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        accept    = in_valid_i & ready_q & ~flush_i;
        a_free    = ~a_valid_q | out_ready_i;

        if (flush_i) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else if (a_free) begin
            if (b_valid_q) begin
                a_valid_d = 1'b1;
                a_data_d  = b_data_q;
                b_valid_d = 1'b0;
            end else begin
                a_valid_d = accept;
                if (accept) begin
                    a_data_d = in_data_i;
                end
            end
        end else if (accept) begin
            b_valid_d = 1'b1;
            b_data_d  = in_data_i;
        end

        ready_d = ~b_valid_d;
    end

    // Entry registers; reset clears payload so outputs read zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            ready_q   <= 1'b1;
        end else begin
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
            ready_q   <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = a_valid_q;
    assign out_data_o  = a_data_q;

endmodule

// File: rtl/alu_operand_issue.sv
// Decode/issue stage: RV32I instruction + register data -> ALU operands and opcode,
// issued one cycle later through a 2-entry skid buffer.
module alu_operand_issue
    import alu_issue_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    alu_operand_issue_if.slave bus
);

    logic [INSTR_W-1:0] instr;
    logic [6:0]         opcode;
    logic [REG_W-1:0]   rd;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_s;
    logic [XLEN-1:0]    imm_u;
    logic [XLEN-1:0]    shamt_imm;
    logic [XLEN-1:0]    shamt_reg;
    logic               legal;
    issue_payload_t     dec;
    logic [PAYLOAD_W-1:0] dec_vec;
    logic [PAYLOAD_W-1:0] out_vec;
    logic               out_valid;
    logic               in_ready;

    assign instr     = bus.instr_in;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s     = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u     = {instr[31:12], 12'b0};
    assign shamt_imm = XLEN'(instr[24:20]);
    assign shamt_reg = XLEN'(bus.rs2_data_in[4:0]);

    // Instruction decode into the issue payload; unsupported encodings issue as zeroed ADD
    always_comb begin
        dec            = '0;
        dec.alu_opcode = ALU_ADD;
        legal          = 1'b0;

        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
                dec.op_1       = bus.rs1_data_in;
                dec.op_2       = ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) ? shamt_reg
                                                                               : bus.rs2_data_in;
                dec.alu_opcode = {funct7[5], funct3};
            end
            OPC_OP_IMM: begin
                dec.op_1 = bus.rs1_data_in;
                if (funct3 == F3_SLL) begin
                    legal          = (funct7 == F7_BASE);
                    dec.op_2       = shamt_imm;
                    dec.alu_opcode = ALU_SLL;
                end else if (funct3 == F3_SRL_SRA) begin
                    legal          = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    dec.op_2       = shamt_imm;
                    dec.alu_opcode = instr[30] ? ALU_SRA : ALU_SRL;
                end else begin
                    legal          = 1'b1;
                    dec.op_2       = imm_i;
                    dec.alu_opcode = {1'b0, funct3};
                end
            end
            OPC_LUI: begin
                legal    = 1'b1;
                dec.op_2 = imm_u;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                dec.op_1 = bus.pc_in;
                dec.op_2 = imm_u;
            end
            OPC_LOAD: begin
                legal    = 1'b1;
                dec.op_1 = bus.rs1_data_in;
                dec.op_2 = imm_i;
            end
            OPC_STORE: begin
                legal    = 1'b1;
                dec.op_1 = bus.rs1_data_in;
                dec.op_2 = imm_s;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (!legal) begin
            dec.op_1       = '0;
            dec.op_2       = '0;
            dec.alu_opcode = ALU_ADD;
        end

        dec.rd_addr  = rd;
        dec.illegal  = ~legal;
        dec.rd_wr_en = legal && (rd != '0) && (opcode != OPC_STORE);
    end

    assign dec_vec = dec;

    alu_issue_skid #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .flush_i     (bus.flush_in),
        .in_valid_i  (bus.instr_valid_in),
        .in_ready_o  (in_ready),
        .in_data_i   (dec_vec),
        .out_valid_o (out_valid),
        .out_ready_i (bus.issue_ready_in),
        .out_data_o  (out_vec)
    );

    assign bus.instr_ready_out = in_ready;
    assign bus.issue_valid_out = out_valid;
    assign bus.op_1_out        = out_vec[PL_OP1_LSB +: XLEN];
    assign bus.op_2_out        = out_vec[PL_OP2_LSB +: XLEN];
    assign bus.alu_opcode_out  = out_vec[PL_OPC_LSB +: OPC_W];
    assign bus.rd_addr_out     = out_vec[PL_RD_LSB +: REG_W];
    assign bus.rd_wr_en_out    = out_vec[PL_WR_EN_LSB];
    assign bus.illegal_out     = out_vec[PL_ILLEGAL_LSB];

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed cases plus random traffic against a reference decoder
// and an in-order scoreboard.
module tb_alu_operand_issue;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   issued;
    bit   last_acc;
    bit   stall_prev;
    logic [74:0] prev_pl;
    exp_t exp_q[$];

    alu_operand_issue_if bus ();

    alu_operand_issue dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decoder written straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 0;
        e.op1 = 0; e.op2 = 0; e.opc = 0;
        if (op == 7'h33) begin
            ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.op1 = a;
            e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? (b & 32'h1f) : b;
            e.opc = {f7[5], f3};
        end else if (op == 7'h13) begin
            e.op1 = a;
            if (f3 == 3'd1) begin
                ok = (f7 == 7'h00); e.op2 = 32'(ins[24:20]); e.opc = 4'd1;
            end else if (f3 == 3'd5) begin
                ok = (f7 == 7'h00 || f7 == 7'h20); e.op2 = 32'(ins[24:20]);
                e.opc = ins[30] ? 4'd13 : 4'd5;
            end else begin
                ok = 1; e.op2 = 32'($signed(ins[31:20])); e.opc = {1'b0, f3};
            end
        end else if (op == 7'h37) begin
            ok = 1; e.op2 = ins & 32'hFFFF_F000;
        end else if (op == 7'h17) begin
            ok = 1; e.op1 = pc; e.op2 = ins & 32'hFFFF_F000;
        end else if (op == 7'h03) begin
            ok = 1; e.op1 = a; e.op2 = 32'($signed(ins[31:20]));
        end else if (op == 7'h23) begin
            ok = 1; e.op1 = a; e.op2 = 32'($signed({ins[31:25], ins[11:7]}));
        end
        if (!ok) begin
            e.op1 = 0; e.op2 = 0; e.opc = 0;
        end
        e.rd  = ins[11:7];
        e.ill = !ok;
        e.wr  = ok && (ins[11:7] != 5'd0) && (op != 7'h23);
        return e;
    endfunction

    function automatic logic [74:0] pack(input exp_t e);
        return {e.op1, e.op2, e.opc, e.rd, e.wr, e.ill};
    endfunction

    function automatic logic [74:0] cur_pl();
        return {bus.op_1_out, bus.op_2_out, bus.alu_opcode_out, bus.rd_addr_out,
                bus.rd_wr_en_out, bus.illegal_out};
    endfunction

    // One clock: observe handshakes at the negative edge, then advance past the next rising edge
    task automatic step();
        exp_t e;
        logic [74:0] cur;
        @(negedge clk);
        cur = cur_pl();
        if (stall_prev) begin
            chk("hold_valid", 96'(bus.issue_valid_out), 96'(1'b1));
            chk("hold_payload", 96'(cur), 96'(prev_pl));
        end
        if (bus.issue_valid_out && bus.issue_ready_in) begin
            issued++;
            if (exp_q.size() == 0) begin
                chk("spurious_issue", 96'(1'b1), 96'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("issue_payload", 96'(cur), 96'(pack(e)));
            end
        end
        if (bus.flush_in) exp_q.delete();
        last_acc = bus.instr_valid_in && bus.instr_ready_out && !bus.flush_in;
        if (last_acc) exp_q.push_back(ref_decode(bus.instr_in, bus.pc_in,
                                                 bus.rs1_data_in, bus.rs2_data_in));
        stall_prev = bus.issue_valid_out && !bus.issue_ready_in && !bus.flush_in;
        prev_pl    = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        bus.instr_valid_in = v;
        bus.instr_in       = ins;
        bus.pc_in          = pc;
        bus.rs1_data_in    = a;
        bus.rs2_data_in    = b;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [7];
        logic [6:0]  f7;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17;
        ops[4] = 7'h03; ops[5] = 7'h23; ops[6] = 7'($urandom);
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 6)];
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h00;
            default: f7 = 7'($urandom);
        endcase
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) ins[31:25] = f7;
        return ins;
    endfunction

    initial begin
        int k;
        int base;
        logic [31:0] stream [4];
        tests = 0; fails = 0; issued = 0; last_acc = 0; stall_prev = 0; prev_pl = '0;
        rst = 1'b1;
        bus.flush_in = 1'b0;
        bus.issue_ready_in = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        #12;
        chk("rst_valid", 96'(bus.issue_valid_out), 96'(1'b0));
        chk("rst_ready", 96'(bus.instr_ready_out), 96'(1'b1));
        chk("rst_payload", 96'(cur_pl()), 96'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // ADDI x1,x2,-1 with latency check
        bus.issue_ready_in = 1'b1;
        drive(1'b1, 32'hFFF10093, 32'h40, 32'd5, 32'd9);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("addi_valid", 96'(bus.issue_valid_out), 96'(1'b1));
        chk("addi_op1", 96'(bus.op_1_out), 96'(32'd5));
        chk("addi_op2", 96'(bus.op_2_out), 96'(32'hFFFF_FFFF));
        chk("addi_opc", 96'(bus.alu_opcode_out), 96'(4'b0000));
        chk("addi_rd", 96'(bus.rd_addr_out), 96'(5'd1));
        chk("addi_wr", 96'(bus.rd_wr_en_out), 96'(1'b1));

        // SRAI x3,x4,31
        drive(1'b1, 32'h41F25193, 32'h44, 32'h8000_0000, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("srai_op2", 96'(bus.op_2_out), 96'(32'd31));
        chk("srai_opc", 96'(bus.alu_opcode_out), 96'(4'b1101));
        chk("srai_rd", 96'(bus.rd_addr_out), 96'(5'd3));
        chk("srai_ill", 96'(bus.illegal_out), 96'(1'b0));

        // SLL x5,x6,x7: register shift amount masked to 5 bits
        drive(1'b1, 32'h007312B3, 32'h48, 32'h77, 32'h123);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("sll_op2", 96'(bus.op_2_out), 96'(32'h3));
        chk("sll_opc", 96'(bus.alu_opcode_out), 96'(4'b0001));
        step();
        chk("sll_drained", 96'(bus.issue_valid_out), 96'(1'b0));

        // Back-to-back traffic with a ready sink: no bubbles
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, {12'(i * 3 + 1), 5'd2, 3'b000, 5'd4, 7'h13}, 32'(i), 32'(i * 100), 32'h0);
            step();
            chk("nobubble_valid", 96'(bus.issue_valid_out), 96'(1'b1));
            chk("nobubble_ready", 96'(bus.instr_ready_out), 96'(1'b1));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("nobubble_empty", 96'(exp_q.size()), 96'(0));

        // Stall 3 cycles with stream I0..I3: two held, ready low, then in order
        stream[0] = 32'h00A00093; stream[1] = 32'h40208133;
        stream[2] = 32'h123451B7; stream[3] = 32'h00C12223;
        k = 0;
        base = issued;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            bus.issue_ready_in = (cyc >= 3);
            drive(1'b1, stream[k], 32'h1000 + 32'(k * 4), 32'h11 * 32'(k + 1), 32'h22 * 32'(k + 1));
            step();
            if (last_acc) k++;
            if (cyc == 2) begin
                chk("stall_ready_low", 96'(bus.instr_ready_out), 96'(1'b0));
                chk("stall_valid", 96'(bus.issue_valid_out), 96'(1'b1));
                chk("stall_held", 96'(exp_q.size()), 96'(2));
            end
        end
        chk("stream_accepted", 96'(k), 96'(4));
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("stream_issued", 96'(issued - base), 96'(4));
        chk("stream_empty", 96'(exp_q.size()), 96'(0));

        // JAL is illegal; then flush while two entries are held
        bus.issue_ready_in = 1'b0;
        drive(1'b1, 32'h0000006F, 32'h200, 32'h33, 32'h44);
        step();
        chk("jal_ill", 96'(bus.illegal_out), 96'(1'b1));
        chk("jal_opc", 96'(bus.alu_opcode_out), 96'(4'b0000));
        chk("jal_ops", 96'({bus.op_1_out, bus.op_2_out}), 96'(0));
        chk("jal_wr", 96'(bus.rd_wr_en_out), 96'(1'b0));
        drive(1'b1, 32'h00500293, 32'h204, 32'h1, 32'h2);
        step();
        chk("flush_pre_ready", 96'(bus.instr_ready_out), 96'(1'b0));
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
        chk("flush_valid", 96'(bus.issue_valid_out), 96'(1'b0));
        chk("flush_ready", 96'(bus.instr_ready_out), 96'(1'b1));
        // Flush with an incoming instruction discards it
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("flush_discard", 96'(bus.issue_valid_out), 96'(1'b0));
        bus.issue_ready_in = 1'b1;
        step();
        chk("flush_quiet", 96'(bus.issue_valid_out), 96'(1'b0));

        // Asynchronous reset in the middle of a stall
        bus.issue_ready_in = 1'b0;
        drive(1'b1, 32'h00100093, 32'h300, 32'h5, 32'h6);
        step();
        drive(1'b1, 32'h00200113, 32'h304, 32'h7, 32'h8);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_valid", 96'(bus.issue_valid_out), 96'(1'b0));
        chk("amid_rst_ready", 96'(bus.instr_ready_out), 96'(1'b1));
        chk("amid_rst_payload", 96'(cur_pl()), 96'(0));
        #2 rst = 1'b0;
        exp_q.delete();
        stall_prev = 0;
        @(posedge clk); #1;
        bus.issue_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", 96'(bus.issue_valid_out), 96'(1'b0));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom);
            bus.issue_ready_in = 1'($urandom_range(0, 2) != 0);
            bus.flush_in       = 1'($urandom_range(0, 31) == 0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.flush_in = 1'b0;
        bus.issue_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("random_drained", 96'(exp_q.size()), 96'(0));
        chk("random_idle", 96'(bus.issue_valid_out), 96'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
